buffer_read_scheduler: RTL and testbench
========================================

# buffer_read_scheduler

Drains the four 6-entry packet buffers filled by the button-driven intake stage and delivers one packet at a time to a downstream consumer (display/decoder). It tracks per-buffer occupancy and read pointers from the intake's push strobes, arbitrates round-robin among non-empty buffers, and presents the selected entry on a valid/ready output. It enforces a programmable idle gap between deliveries and flags overflow.

## Interface
- DEPTH, 6, entries per buffer; the intake write index wraps DEPTH-1 → 0.
- GAP, 3, idle cycles after each handshake before the next selection; 0 is legal.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push  in  4  one-hot or zero; bit k pulses for one cycle on the same edge the intake writes buffer k+1.
- buf1_i, buf2_i, buf3_i, buf4_i  in  18 each  flattened buffers; slot s occupies bits [3s+2:3s], with {data[1:0], valid} and valid at bit 3s.
- rd_ready  in  1  consumer accepts the offered packet.
- rd_valid  out  1  packet offered.
- rd_buf  out  2  source buffer index (0–3).
- rd_slot  out  3  source slot (0–5).
- rd_data  out  2  packet payload.
- occ  out  12  occupancy; buffer k uses bits [3k+2:3k], range 0–6.
- overflow  out  4  sticky per buffer; set by a push into a full buffer.
- err  out  1  sticky; set when a selected slot has valid=0.

## Operation
- **Per-buffer state:** occupancy `occ_k` (0..DEPTH) and read pointer `rptr_k` (0..DEPTH-1, wraps DEPTH-1 → 0).
- **Push to buffer k, not full:** `occ_k` increments.
- **Push to buffer k, full:**
  - `occ_k` stays at DEPTH, `rptr_k` advances by one (the oldest entry is overwritten), and `overflow[k]` is set.
  - If buffer k is currently offered, a stale flag is set.
- **Pop** (rd_valid & rd_ready, buffer k):
  - `occ_k` decrements, `rptr_k` advances, and the round-robin pointer becomes k+1 mod 4.
  - If stale is set, the pop skips the decrement and the advance, but still updates the round-robin pointer; stale then clears.
- **Push and pop on the same buffer in the same cycle:**
  - `occ_k` is unchanged.
  - If the buffer was full, `rptr_k` advances exactly once and overflow is set.
- **FSM:**
  - IDLE: all occ = 0. Go to SEL when any occ is non-zero.
  - SEL: pick the first non-empty buffer at or after the round-robin pointer, then read slot `rptr_k` of that buffer.
    - If the slot's valid bit is 1: latch rd_buf/rd_slot/rd_data and go to OFFER.
    - If the valid bit is 0: set err, pop without output, then go to GAP.
  - OFFER: rd_valid=1; rd_* held stable until rd_ready. On the handshake, go to GAP, or to SEL/IDLE directly if GAP=0.
  - GAP: count GAP cycles, then go to SEL or IDLE.
- **Overwrite while offered:** rd_data is registered, so the offered value does not change.

## Timing
- **Reset values:** rd_valid=0, rd_buf=0, rd_slot=0, rd_data=0, occ=0, overflow=0, err=0, round-robin pointer=0, all rptr=0, FSM in IDLE.
- **Reset is asynchronous.** Asserting rst_n low mid-OFFER drops rd_valid immediately, with no handshake and no pop.
- **Push-to-offer latency:**
  - Push at edge t makes occ visible after t.
  - SEL occurs in cycle t+1.
  - rd_valid is asserted after edge t+2.
  - So an empty scheduler produces rd_valid two cycles after push.
- **Handshake:** completes at the edge where rd_valid & rd_ready. rd_valid deasserts after that edge.
- **Minimum spacing:** between consecutive rd_valid assertions it is GAP+2 cycles, with rd_ready held high.
- **rd_ready while rd_valid=0:** ignored.
- **occ:** registered, updated one edge after the push or pop.

## Test plan
- **Single push then drain:** push=0001, buf1 slot0=3'b101. Expect rd_valid 2 cycles later, rd_buf=0, rd_slot=0, rd_data=2'b10. With rd_ready=1, occ[2:0] returns 1 → 0.
- **Round-robin:** push two entries each to buffers 0 and 2, keep rd_ready=1. Expect rd_buf order 0,2,0,2. Expect spacing GAP+2=5 cycles between rd_valid rises.
- **Overflow:** push seven times to buffer 3 with rd_ready=0. Expect:
  - occ[11:9]=6 and overflow=1000.
  - rd_slot of the pending offer is 0, with stale set.
  - After the handshake, occ stays 6. The next offer is rd_slot=1.
- **Backpressure:** rd_ready low for 10 cycles while offering. Expect rd_valid and rd_* stable throughout. Raising rd_ready pops exactly one entry.
- **Invalid slot:** push=0010 with buf2 slot0 valid bit = 0. Expect err=1, no rd_valid, and occ[5:3] returns to 0.
- **Reset mid-offer:** assert rst_n low while rd_valid=1. Expect all outputs at reset values asynchronously. After release, the scheduler stays IDLE until a new push.

Source files
------------

// File: rtl/buffer_read_scheduler.sv
// buffer_read_scheduler: drains four packet buffers written by the intake
// stage. It tracks occupancy and read pointers from the push strobes,
// arbitrates round-robin among non-empty buffers, offers one packet at a time
// on a registered valid/ready port, and inserts an idle gap between deliveries.
module buffer_read_scheduler #(
  parameter int DEPTH = 6,
  parameter int GAP   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  push,
  input  logic [17:0] buf1_i,
  input  logic [17:0] buf2_i,
  input  logic [17:0] buf3_i,
  input  logic [17:0] buf4_i,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [1:0]  rd_buf,
  output logic [2:0]  rd_slot,
  output logic [1:0]  rd_data,
  output logic [11:0] occ,
  output logic [3:0]  overflow,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SEL, OFFER, GAP_S} state_t;

  localparam logic [2:0] FULL     = 3'(DEPTH);
  localparam logic [2:0] LAST     = 3'(DEPTH - 1);
  localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t          state, post_pop;
  logic [3:0][2:0] cnt_q, cnt_n;
  logic [3:0][2:0] rptr_q, rptr_n;
  logic [3:0]      ovf_n;
  logic [3:0]      full;
  logic [3:0]      pop_vec;
  logic [1:0]      rr_q, rr_n;
  logic            stale_q, stale_n;
  logic [7:0]      gap_cnt;
  logic [17:0]     bufs [4];
  logic [1:0]      sel_idx, cand;
  logic            sel_found;
  logic [2:0]      sel_rptr;
  logic [4:0]      sel_lsb;
  logic [2:0]      slot_bits;
  logic            sel_pop, hs, skip, next_any;

  assign bufs[0] = buf1_i;
  assign bufs[1] = buf2_i;
  assign bufs[2] = buf3_i;
  assign bufs[3] = buf4_i;
  assign occ     = cnt_q;

  // Round-robin pick of the first non-empty buffer at or after rr_q, and the slot it points at.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = rr_q;
    cand      = rr_q;
    for (int i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (!sel_found && cnt_q[cand] != 3'd0) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    for (int k = 0; k < 4; k++) full[k] = (cnt_q[k] == FULL);
    sel_rptr  = rptr_q[sel_idx];
    sel_lsb   = 5'(sel_rptr) * 5'd3;
    slot_bits = bufs[sel_idx][sel_lsb +: 3];
  end

  // Next occupancy, read pointers, overflow, stale flag and round-robin pointer.
  always_comb begin
    sel_pop = (state == SEL) && sel_found && !slot_bits[0];
    hs      = (state == OFFER) && rd_ready;
    // A stale offer was already discarded by an overwrite, so its pop moves nothing.
    skip    = hs && stale_q;
    pop_vec = '0;
    if (sel_pop)     pop_vec[sel_idx] = 1'b1;
    if (hs && !skip) pop_vec[rd_buf]  = 1'b1;

    rr_n = rr_q;
    if (sel_pop) rr_n = sel_idx + 2'd1;
    if (hs)      rr_n = rd_buf + 2'd1;

    stale_n = stale_q;
    if (hs)                                                  stale_n = 1'b0;
    else if (state == OFFER && push[rd_buf] && full[rd_buf]) stale_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      cnt_n[k]  = cnt_q[k];
      rptr_n[k] = rptr_q[k];
      ovf_n[k]  = overflow[k];
      if (push[k] && full[k]) ovf_n[k] = 1'b1;
      // An overwrite and a pop in the same cycle both retire the oldest entry: advance once.
      if ((push[k] && full[k]) || pop_vec[k])
        rptr_n[k] = (rptr_q[k] == LAST) ? 3'd0 : rptr_q[k] + 3'd1;
      if (push[k] && !pop_vec[k] && !full[k]) cnt_n[k] = cnt_q[k] + 3'd1;
      else if (!push[k] && pop_vec[k])        cnt_n[k] = cnt_q[k] - 3'd1;
    end

    next_any = |cnt_n;
    post_pop = (GAP == 0) ? (next_any ? SEL : IDLE) : GAP_S;
  end

  // Per-buffer bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rptr_q   <= '0;
      overflow <= '0;
      rr_q     <= '0;
      stale_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      cnt_q    <= cnt_n;
      rptr_q   <= rptr_n;
      overflow <= ovf_n;
      rr_q     <= rr_n;
      stale_q  <= stale_n;
    end
  end

  // Delivery FSM with registered offer outputs and the inter-delivery gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_valid <= 1'b0;
      rd_buf   <= 2'd0;
      rd_slot  <= 3'd0;
      rd_data  <= 2'd0;
      err      <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (|cnt_q) state <= SEL;
        SEL: begin
          if (!sel_found) begin
            state <= IDLE;
          end else if (slot_bits[0]) begin
            rd_valid <= 1'b1;
            rd_buf   <= sel_idx;
            rd_slot  <= sel_rptr;
            rd_data  <= slot_bits[2:1];
            state    <= OFFER;
          end else begin
            err     <= 1'b1;
            gap_cnt <= GAP_LOAD;
            state   <= post_pop;
          end
        end
        OFFER: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            gap_cnt  <= GAP_LOAD;
            state    <= post_pop;
          end
        end
        GAP_S: begin
          if (gap_cnt == 8'd0) state <= (|cnt_q) ? SEL : IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_read_scheduler.sv
// tb_buffer_read_scheduler: acts as the intake stage and the consumer, and
// checks every cycle against a behavioural model of the scheduling rules.
module tb_buffer_read_scheduler;

  localparam int DEPTH = 6;
  localparam int GAP   = 3;

  typedef enum int {M_IDLE, M_SEL, M_OFFER, M_GAP} mph_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  push;
  logic [17:0] bufv [4];
  logic        rd_ready;
  logic        rd_valid;
  logic [1:0]  rd_buf;
  logic [2:0]  rd_slot;
  logic [1:0]  rd_data;
  logic [11:0] occ;
  logic [3:0]  overflow;
  logic        err;

  buffer_read_scheduler #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .push(push),
    .buf1_i(bufv[0]), .buf2_i(bufv[1]), .buf3_i(bufv[2]), .buf4_i(bufv[3]),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_buf(rd_buf), .rd_slot(rd_slot),
    .rd_data(rd_data), .occ(occ), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Intake contents as written by the bench.
  logic [2:0] mem [4][DEPTH];
  int         widx [4];

  // Behavioural model state.
  mph_t     m_ph;
  int       m_occ [4];
  int       m_rptr [4];
  int       m_rr, m_gap, m_buf, m_slot, m_data;
  bit [3:0] m_ovf;
  bit       m_err, m_stale, m_valid;

  int cyc = 0;
  bit prev_valid;
  int rise_cyc [$];
  int rise_buf [$];
  int rise_data [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int occ_sum();
    int s = 0;
    for (int k = 0; k < 4; k++) s += m_occ[k];
    return s;
  endfunction

  task automatic drive_bufs();
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < DEPTH; s++) bufv[k][3*s +: 3] = mem[k][s];
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_rr = 0; m_gap = 0; m_buf = 0; m_slot = 0; m_data = 0;
    m_ovf = '0; m_err = 0; m_stale = 0; m_valid = 0;
    for (int k = 0; k < 4; k++) begin m_occ[k] = 0; m_rptr[k] = 0; end
  endtask

  // One clock edge of the scheduling rules, using the buffer contents visible before the edge.
  task automatic model_step(input logic [3:0] p, input bit r);
    int   tgt = -1;
    int   k0 = -1;
    bit   hs = 0;
    bit   skip, pushed, popped, full;
    mph_t ph_next = m_ph;
    bit   was_offer = (m_ph == M_OFFER);
    int   off_buf = m_buf;
    logic [2:0] e;
    case (m_ph)
      M_IDLE: if (occ_sum() > 0) ph_next = M_SEL;
      M_SEL: begin
        for (int i = 0; i < 4; i++)
          if (k0 < 0 && m_occ[(m_rr + i) % 4] > 0) k0 = (m_rr + i) % 4;
        if (k0 < 0) ph_next = M_IDLE;
        else begin
          e = mem[k0][m_rptr[k0]];
          if (e[0]) begin
            m_valid = 1; m_buf = k0; m_slot = m_rptr[k0]; m_data = int'(e[2:1]);
            ph_next = M_OFFER;
          end else begin
            m_err = 1; tgt = k0;
          end
        end
      end
      M_OFFER: if (r) begin hs = 1; tgt = m_buf; m_valid = 0; end
      default: if (m_gap == 0) ph_next = (occ_sum() > 0) ? M_SEL : M_IDLE;
               else m_gap--;
    endcase
    skip = hs && m_stale;
    for (int k = 0; k < 4; k++) begin
      pushed = p[k];
      popped = (tgt == k) && !skip;
      full   = (m_occ[k] == DEPTH);
      if (pushed && full) begin
        m_ovf[k] = 1;
        if (was_offer && off_buf == k && !hs) m_stale = 1;
      end
      if ((pushed && full) || popped) m_rptr[k] = (m_rptr[k] + 1) % DEPTH;
      m_occ[k] = m_occ[k] + int'(pushed) - int'(popped);
      if (m_occ[k] > DEPTH) m_occ[k] = DEPTH;
    end
    if (hs) m_stale = 0;
    if (tgt >= 0) begin
      m_rr = (tgt + 1) % 4;
      if (GAP == 0) ph_next = (occ_sum() > 0) ? M_SEL : M_IDLE;
      else begin ph_next = M_GAP; m_gap = GAP - 1; end
    end
    m_ph = ph_next;
  endtask

  task automatic compare_outputs();
    logic [11:0] eo;
    for (int k = 0; k < 4; k++) eo[3*k +: 3] = 3'(m_occ[k]);
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    check("rd_buf",   32'(rd_buf),   32'(m_buf));
    check("rd_slot",  32'(rd_slot),  32'(m_slot));
    check("rd_data",  32'(rd_data),  32'(m_data));
    check("occ",      32'(occ),      32'(eo));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("err",      32'(err),      32'(m_err));
  endtask

  // One cycle: check at the falling edge, drive inputs, then advance the model past the rising edge.
  task automatic cycle(input logic [3:0] p, input bit r, input logic [2:0] entry);
    @(negedge clk);
    cyc++;
    compare_outputs();
    if (rd_valid && !prev_valid) begin
      rise_cyc.push_back(cyc);
      rise_buf.push_back(int'(rd_buf));
      rise_data.push_back(int'(rd_data));
    end
    prev_valid = rd_valid;
    push = p;
    rd_ready = r;
    @(posedge clk);
    #1;
    model_step(p, r);
    for (int k = 0; k < 4; k++)
      if (p[k]) begin
        mem[k][widx[k]] = entry;
        widx[k] = (widx[k] + 1) % DEPTH;
      end
    drive_bufs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push = '0;
    rd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      widx[k] = 0;
      for (int s = 0; s < DEPTH; s++) mem[k][s] = 3'd0;
    end
    drive_bufs();
    model_reset();
    prev_valid = 0;
    rise_cyc.delete(); rise_buf.delete(); rise_data.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_offer();
    int n = 0;
    while (!rd_valid && n < 50) begin cycle(4'b0000, 1'b0, 3'd0); n++; end
    check("offer_timeout", 32'(rd_valid), 32'd1);
  endtask

  initial begin
    int pc;
    int exp_rr [4] = '{0, 2, 0, 2};
    logic [1:0] hb, hd;
    logic [2:0] hsl;
    logic [3:0] p;

    // Reset values.
    do_reset();
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_occ",   32'(occ),      32'd0);
    check("reset_ovf",   32'(overflow), 32'd0);
    check("reset_err",   32'(err),      32'd0);

    // Single push then drain: offer two edges after the push, observed at the next falling edge.
    pc = cyc + 1;
    cycle(4'b0001, 1'b1, 3'b101);
    repeat (8) cycle(4'b0000, 1'b1, 3'd0);
    check("single_rises", 32'(rise_cyc.size()), 32'd1);
    if (rise_cyc.size() >= 1) begin
      check("single_latency", 32'(rise_cyc[0] - pc), 32'd3);
      check("single_buf",     32'(rise_buf[0]),      32'd0);
      check("single_data",    32'(rise_data[0]),     32'd2);
    end
    check("single_occ_end", 32'(occ[2:0]), 32'd0);

    // Round-robin between buffers 0 and 2 with the minimum spacing.
    do_reset();
    cycle(4'b0001, 1'b1, 3'b011);
    cycle(4'b0100, 1'b1, 3'b101);
    cycle(4'b0001, 1'b1, 3'b111);
    cycle(4'b0100, 1'b1, 3'b001);
    repeat (30) cycle(4'b0000, 1'b1, 3'd0);
    check("rr_rises", 32'(rise_cyc.size()), 32'd4);
    if (rise_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", 32'(rise_buf[i]), 32'(exp_rr[i]));
      for (int i = 0; i < 3; i++) check("rr_spacing", 32'(rise_cyc[i+1] - rise_cyc[i]), 32'(GAP + 2));
    end

    // Overflow of buffer 3 while its oldest entry is on offer.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(4'b1000, 1'b0, {2'(i), 1'b1});
    check("ovf_occ",   32'(occ[11:9]), 32'd6);
    check("ovf_flags", 32'(overflow),  32'b1000);
    check("ovf_valid", 32'(rd_valid),  32'd1);
    check("ovf_slot",  32'(rd_slot),   32'd0);
    cycle(4'b0000, 1'b1, 3'd0);
    check("ovf_occ_after", 32'(occ[11:9]), 32'd6);
    wait_offer();
    check("ovf_next_slot", 32'(rd_slot), 32'd1);
    repeat (60) cycle(4'b0000, 1'b1, 3'd0);

    // Backpressure: offer held stable, then exactly one pop.
    do_reset();
    cycle(4'b0010, 1'b0, 3'b111);
    cycle(4'b0010, 1'b0, 3'b011);
    wait_offer();
    hb = rd_buf; hsl = rd_slot; hd = rd_data;
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0000, 1'b0, 3'd0);
      check("bp_valid", 32'(rd_valid), 32'd1);
      check("bp_hold",  32'({rd_buf, rd_slot, rd_data}), 32'({hb, hsl, hd}));
    end
    cycle(4'b0000, 1'b1, 3'd0);
    check("bp_pop_one", 32'(occ[5:3]), 32'd1);
    check("bp_drop",    32'(rd_valid), 32'd0);

    // Invalid slot: error, no offer, entry discarded.
    do_reset();
    cycle(4'b0010, 1'b1, 3'b100);
    repeat (6) cycle(4'b0000, 1'b1, 3'd0);
    check("inv_err",   32'(err),              32'd1);
    check("inv_rises", 32'(rise_cyc.size()),  32'd0);
    check("inv_occ",   32'(occ[5:3]),         32'd0);

    // Asynchronous reset during an offer.
    do_reset();
    cycle(4'b0001, 1'b0, 3'b111);
    wait_offer();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(rd_valid), 32'd0);
    check("arst_outs",  32'({rd_buf, rd_slot, rd_data, err}), 32'd0);
    check("arst_occ",   32'(occ),      32'd0);
    do_reset();
    repeat (6) cycle(4'b0000, 1'b1, 3'd0);
    check("arst_idle", 32'(rise_cyc.size()), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      cycle(p, ($urandom_range(0, 9) < 6), {2'($urandom_range(0, 3)), ($urandom_range(0, 9) != 0)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
